// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC vectoring-mode sequencer: sign-block
// encodings, FSM state type and the default micro-rotation count.
package cordic_pkg;

  localparam logic [1:0] SIGN_POS  = 2'b01;
  localparam logic [1:0] SIGN_NEG  = 2'b11;
  localparam logic [1:0] SIGN_ZERO = 2'b00;

  localparam int ITERATIONS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    PRE   = 3'd3,
    ITER  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Only the explicit negative code counts as negative.
  function automatic logic sign_is_neg(input logic [1:0] s);
    return (s == SIGN_NEG);
  endfunction

  // The unused code 2'b10 is folded into zero.
  function automatic logic sign_is_zero(input logic [1:0] s);
    return (s == SIGN_ZERO) || (s == 2'b10);
  endfunction

endpackage

// File: rtl/cordic_iter_cnt.sv
// Micro-rotation index counter: synchronous clear, count enable, and a
// terminal-count flag at ITERATIONS-1. The count saturates there and never
// wraps, so the last index stays visible while the result is presented.
module cordic_iter_cnt #(
  parameter int ITERATIONS = 16,
  parameter int ITER_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ITER_W-1:0] cnt,
  output logic              tc
);

  localparam logic [ITER_W-1:0] LAST = ITER_W'(ITERATIONS - 1);

  assign tc = (cnt == LAST);

  // Index register: clear wins over enable; saturate at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + ITER_W'(1);
    end
  end

endmodule

// File: rtl/cordic_vec_ctrl.sv
// Sequencing controller for the CORDIC vectoring-mode datapath.
// Optional feature: define CORDIC_EARLY_EXIT_EN to finish as soon as the
// y sign block reports exactly zero during the micro-rotation phase.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_valid; start_ready high
// LOAD  | ld strobe: datapath captures x, y and clears z
// CHECK | x sign sampled to decide on the 180-degree correction
// PRE   | pre_rot strobe: x=-x, y=-y, z=pi
// ITER  | one micro-rotation per cycle, iter_idx 0..ITERATIONS-1
// DONE  | res_valid held until res_ready
//
// All strobes are registered from the next state, so each appears in the
// cycle the FSM is in the matching state.
module cordic_vec_ctrl
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = ITERATIONS_DEF,
  parameter int ITER_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              abort,
  input  logic [1:0]        x_sign,
  input  logic [1:0]        y_sign,
  output logic              ld,
  output logic              pre_rot,
  output logic              iter_en,
  output logic [ITER_W-1:0] iter_idx,
  output logic              dir,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready
);

  state_t state;
  state_t state_nxt;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;
  logic   y_exit;

`ifdef CORDIC_EARLY_EXIT_EN
  assign y_exit = sign_is_zero(y_sign);
`else
  assign y_exit = 1'b0;
`endif

  assign start_ready = (state == IDLE);

  cordic_iter_cnt #(
    .ITERATIONS (ITERATIONS),
    .ITER_W     (ITER_W)
  ) u_iter_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (iter_idx),
    .tc  (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus counter control; abort overrides everything
  // except IDLE.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE:  if (start_valid) state_nxt = LOAD;
      LOAD:  state_nxt = CHECK;
      CHECK: begin
        cnt_clr   = 1'b1;
        state_nxt = sign_is_neg(x_sign) ? PRE : ITER;
      end
      PRE: begin
        cnt_clr   = 1'b1;
        state_nxt = ITER;
      end
      ITER: begin
        if (cnt_tc || y_exit) begin
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
    end
  end

  // Registered Moore outputs; dir samples y_sign one cycle ahead so it lines
  // up with the iter_en cycle it steers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld        <= 1'b0;
      pre_rot   <= 1'b0;
      iter_en   <= 1'b0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      ld        <= (state_nxt == LOAD);
      pre_rot   <= (state_nxt == PRE);
      iter_en   <= (state_nxt == ITER);
      dir       <= (state_nxt == ITER) && !sign_is_neg(y_sign);
      busy      <= (state_nxt != IDLE);
      res_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// Directed bench for cordic_vec_ctrl (ITERATIONS=16, ITER_W=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cordic_vec_ctrl;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic       abort;
  logic [1:0] x_sign;
  logic [1:0] y_sign;
  logic       ld;
  logic       pre_rot;
  logic       iter_en;
  logic [3:0] iter_idx;
  logic       dir;
  logic       busy;
  logic       res_valid;
  logic       res_ready;

  int   checks;
  int   failures;
  logic exp_dir;
  logic seen;

  cordic_vec_ctrl #(
    .ITERATIONS (16),
    .ITER_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .abort       (abort),
    .x_sign      (x_sign),
    .y_sign      (y_sign),
    .ld          (ld),
    .pre_rot     (pre_rot),
    .iter_en     (iter_en),
    .iter_idx    (iter_idx),
    .dir         (dir),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    start_valid = 1'b0;
    abort       = 1'b0;
    x_sign      = 2'b01;
    y_sign      = 2'b01;
    res_ready   = 1'b0;
    exp_dir     = 1'b0;
    seen        = 1'b0;

    // Reset values
    step();
    step();
    chk1("rst_start_ready", start_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ld", ld, 1'b0);
    chk1("rst_iter_en", iter_en, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chkv("rst_iter_idx", 32'(iter_idx), 32'd0);
    rst = 1'b0;
    step();

    // Nominal run, x positive, y sign toggling
    start_valid = 1'b1;
    x_sign      = 2'b01;
    y_sign      = 2'b01;
    chk1("nom_c0_start_ready", start_ready, 1'b1);
    step();
    start_valid = 1'b0;
    chk1("nom_c1_ld", ld, 1'b1);
    chk1("nom_c1_busy", busy, 1'b1);
    chk1("nom_c1_start_ready", start_ready, 1'b0);
    step();
    chk1("nom_c2_ld", ld, 1'b0);
    chk1("nom_c2_iter_en", iter_en, 1'b0);
    chk1("nom_c2_pre_rot", pre_rot, 1'b0);
    exp_dir = 1'b1;
    for (int c = 3; c <= 18; c++) begin
      step();
      chk1($sformatf("nom_c%0d_iter_en", c), iter_en, 1'b1);
      chkv($sformatf("nom_c%0d_iter_idx", c), 32'(iter_idx), 32'(c - 3));
      chk1($sformatf("nom_c%0d_dir", c), dir, exp_dir);
      chk1($sformatf("nom_c%0d_res_valid", c), res_valid, 1'b0);
      y_sign  = c[0] ? 2'b11 : 2'b01;
      exp_dir = (y_sign != 2'b11);
    end
    step();
    chk1("nom_c19_res_valid", res_valid, 1'b1);
    chk1("nom_c19_iter_en", iter_en, 1'b0);
    chk1("nom_c19_busy", busy, 1'b1);
    chkv("nom_c19_iter_idx", 32'(iter_idx), 32'd15);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk1("nom_c20_res_valid", res_valid, 1'b0);
    chk1("nom_c20_start_ready", start_ready, 1'b1);
    chk1("nom_c20_busy", busy, 1'b0);

    // Back-to-back start with pre-rotation (x negative)
    start_valid = 1'b1;
    x_sign      = 2'b11;
    y_sign      = 2'b01;
    step();
    start_valid = 1'b0;
    chk1("pre_c1_ld", ld, 1'b1);
    step();
    chk1("pre_c2_pre_rot", pre_rot, 1'b0);
    step();
    chk1("pre_c3_pre_rot", pre_rot, 1'b1);
    chk1("pre_c3_iter_en", iter_en, 1'b0);
    x_sign = 2'b01;
    for (int c = 4; c <= 19; c++) begin
      step();
      chk1($sformatf("pre_c%0d_iter_en", c), iter_en, 1'b1);
      chkv($sformatf("pre_c%0d_iter_idx", c), 32'(iter_idx), 32'(c - 4));
      chk1($sformatf("pre_c%0d_pre_rot", c), pre_rot, 1'b0);
    end
    step();
    // Backpressure: res_ready low for five cycles (c20..c24)
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      chk1($sformatf("bp_c%0d_res_valid", 20 + k), res_valid, 1'b1);
      chk1($sformatf("bp_c%0d_start_ready", 20 + k), start_ready, 1'b0);
    end
    step();
    res_ready = 1'b1;
    chk1("bp_c25_res_valid", res_valid, 1'b1);
    step();
    res_ready = 1'b0;
    chk1("bp_c26_res_valid", res_valid, 1'b0);
    chk1("bp_c26_start_ready", start_ready, 1'b1);

    // New start accepted in that same cycle; abort at iter_idx 5
    start_valid = 1'b1;
    x_sign      = 2'b01;
    y_sign      = 2'b01;
    step();
    start_valid = 1'b0;
    chk1("ab_c1_ld", ld, 1'b1);
    repeat (7) step();
    chkv("ab_c8_iter_idx", 32'(iter_idx), 32'd5);
    chk1("ab_c8_iter_en", iter_en, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk1("ab_c9_busy", busy, 1'b0);
    chk1("ab_c9_iter_en", iter_en, 1'b0);
    chk1("ab_c9_start_ready", start_ready, 1'b1);
    chk1("ab_c9_res_valid", res_valid, 1'b0);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    chk1("ab_no_res_valid", seen, 1'b0);

    // Post-abort run: x_sign illegal code (no pre-rotation), stray
    // start_valid/res_ready outside their states, y zero at iter_idx 3
    start_valid = 1'b1;
    x_sign      = 2'b10;
    y_sign      = 2'b01;
    res_ready   = 1'b1;
    step();
    chk1("ee_c1_ld", ld, 1'b1);
    chk1("ee_c1_res_valid", res_valid, 1'b0);
    step();
    chk1("ee_c2_pre_rot", pre_rot, 1'b0);
    step();
    start_valid = 1'b0;
    chk1("ee_c3_pre_rot", pre_rot, 1'b0);
    chk1("ee_c3_iter_en", iter_en, 1'b1);
    chkv("ee_c3_iter_idx", 32'(iter_idx), 32'd0);
    for (int c = 4; c <= 6; c++) begin
      step();
      chkv($sformatf("ee_c%0d_iter_idx", c), 32'(iter_idx), 32'(c - 3));
    end
    y_sign = 2'b00;
    step();
    y_sign = 2'b01;
`ifdef CORDIC_EARLY_EXIT_EN
    chk1("ee_c7_iter_en", iter_en, 1'b0);
    chk1("ee_c7_res_valid", res_valid, 1'b1);
    chkv("ee_c7_iter_idx", 32'(iter_idx), 32'd3);
    step();
    chk1("ee_c8_res_valid", res_valid, 1'b0);
    chk1("ee_c8_start_ready", start_ready, 1'b1);
`else
    chk1("ee_c7_iter_en", iter_en, 1'b1);
    chkv("ee_c7_iter_idx", 32'(iter_idx), 32'd4);
    chk1("ee_c7_dir", dir, 1'b1);
    for (int c = 8; c <= 18; c++) begin
      step();
      chk1($sformatf("ee_c%0d_iter_en", c), iter_en, 1'b1);
      chkv($sformatf("ee_c%0d_iter_idx", c), 32'(iter_idx), 32'(c - 3));
    end
    step();
    chk1("ee_c19_res_valid", res_valid, 1'b1);
    chk1("ee_c19_iter_en", iter_en, 1'b0);
    step();
    chk1("ee_c20_res_valid", res_valid, 1'b0);
    chk1("ee_c20_start_ready", start_ready, 1'b1);
`endif
    res_ready = 1'b0;

    // Asynchronous reset in the middle of ITER (iter_idx 7)
    start_valid = 1'b1;
    x_sign      = 2'b01;
    step();
    start_valid = 1'b0;
    repeat (9) step();
    chkv("rm_c10_iter_idx", 32'(iter_idx), 32'd7);
    rst = 1'b1;
    #1;
    chk1("rm_busy", busy, 1'b0);
    chk1("rm_iter_en", iter_en, 1'b0);
    chk1("rm_res_valid", res_valid, 1'b0);
    chk1("rm_start_ready", start_ready, 1'b1);
    chkv("rm_iter_idx", 32'(iter_idx), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk1("rm_after_start_ready", start_ready, 1'b1);
    chk1("rm_after_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_vec_ctrl.md
Name: cordic_vec_ctrl

Overview:
Sequencing controller for the CORDIC vectoring-mode datapath. It accepts a start handshake and commands the datapath to load operands. When x is negative, it issues one pre-rotation. It then steps ITERATIONS micro-rotations, setting each direction from the sign-block output for y, and holds a result-valid handshake until the consumer accepts. It sits between the operand source/consumer and the x/y/z shift-add datapath plus the sign units.

Parameters:
ITERATIONS, 16, number of micro-rotations; legal range 1..2**ITER_W.
ITER_W, 4, width of iter_idx.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
start_valid  input  1  operands are present on the datapath inputs.
start_ready  output  1  controller is idle and can accept a start.
abort  input  1  synchronous cancel of the operation in flight.
x_sign  input  2  sign-block output for the datapath x register.
y_sign  input  2  sign-block output for the datapath y register.
ld  output  1  datapath loads operands (x, y, z=0).
pre_rot  output  1  datapath applies the 180-degree correction: x=-x, y=-y, z=pi.
iter_en  output  1  datapath performs one micro-rotation.
iter_idx  output  ITER_W  shift amount / atan-ROM index for the current micro-rotation.
dir  output  1  1 = rotate clockwise (y>=0: x+=y>>i, y-=x>>i, z+=atan); 0 = counter-clockwise.
busy  output  1  operation in flight.
res_valid  output  1  datapath result is final.
res_ready  input  1  consumer accepts the result.

Behaviour:
- Sign encoding: 2'b01 positive, 2'b11 negative, 2'b00 zero. The illegal code 2'b10 is treated as zero.
- FSM states: IDLE, LOAD, CHECK, PRE, ITER, DONE. State is reset asynchronously to IDLE.
- Reset values: iter_idx=0; ld, pre_rot, iter_en, dir, busy, res_valid all 0. start_ready = (state==IDLE), so it reads 1 during reset.
- All outputs except start_ready are registered (Moore).
- IDLE: on start_valid & start_ready, go to LOAD.
- LOAD: ld=1 for exactly one cycle, then go to CHECK.
- CHECK: sample x_sign.
  - Negative: go to PRE.
  - Otherwise: go to ITER with iter_idx=0.
- PRE: pre_rot=1 for one cycle, then go to ITER with iter_idx=0.
- ITER:
  - iter_en=1.
  - dir = (y_sign != 2'b11), evaluated combinationally into the output register one cycle ahead, so dir is valid in the same cycle as iter_en.
  - iter_idx increments by 1 per cycle.
  - At iter_idx==ITERATIONS-1, go to DONE after that cycle.
  - iter_idx never wraps.
- DONE: res_valid=1, held until res_ready. res_ready in the same cycle returns to IDLE; start_ready is high in the following cycle.
- busy = 1 in every state except IDLE.
- Latency, start accept (cycle 0) to first res_valid cycle: ITERATIONS+3 without pre-rotation, ITERATIONS+4 with it.
- Back-to-back: a new start can be accepted one cycle after res_valid & res_ready.
- abort in any non-IDLE state: return to IDLE on the next edge. All strobes drop; res_valid never rises for that operation. abort in IDLE is ignored.
- abort and res_ready in the same DONE cycle: go to IDLE; the result counts as consumed.
- Asynchronous rst mid-operation: immediately enter IDLE with reset values; no partial handshake is completed.
- res_ready outside DONE and start_valid outside IDLE have no effect.

Optional Feature:
- Macro: CORDIC_EARLY_EXIT_EN.
- Defined: in ITER, if y_sign==2'b00 (y is exactly zero), iter_en is deasserted and the next state is DONE, so latency shrinks. The check uses the value sampled before the current micro-rotation. iter_idx freezes at its last value.
- Undefined: all ITERATIONS micro-rotations always run, regardless of y.

Decomposition:
- Package cordic_pkg: SIGN_POS/SIGN_NEG/SIGN_ZERO constants, the state enum/localparams, and the default ITERATIONS.
- One sub-module, cordic_iter_cnt:
  - ITER_W-bit counter with clear, enable and a terminal-count flag at ITERATIONS-1.
  - Shares clk/rst.
- The FSM stays in cordic_vec_ctrl.

Test Plan:
- Reset: rst=1 mid-ITER (iter_idx=7) -> next sample: busy=0, iter_en=0, res_valid=0, start_ready=1.
- Nominal, ITERATIONS=16, x_sign=01, y_sign toggling 01/11 -> ld at cycle 1; iter_en high at cycles 3..18 with iter_idx 0..15; dir tracks y_sign each cycle; res_valid at cycle 19.
- Pre-rotation: x_sign=11 at CHECK -> pre_rot one cycle at cycle 3; iter_idx=0 at cycle 4; res_valid at cycle 20.
- Backpressure: res_ready=0 for 5 cycles -> res_valid held, start_ready=0 throughout. res_ready=1 -> start_ready=1 next cycle; a new start is accepted that cycle.
- Abort at iter_idx=5 -> IDLE next cycle; res_valid never asserted; the next start runs a full 16 iterations.
- CORDIC_EARLY_EXIT_EN defined, y_sign=00 at iter_idx=3 -> iter_en low, res_valid next cycle. Same stimulus with the macro undefined -> full 16 iterations.
